// File: rtl/cortexm0_wic_pmu_if.sv
// Signal bundle between the PMU, the WIC and the core power controls.
// WICENREQ/WICENACK is a 4-phase handshake: ACK rises after REQ, REQ drops, ACK then follows it low.
interface cortexm0_wic_pmu_if;
  logic       PMUEN;
  logic       SLEEPING;
  logic       SLEEPDEEP;
  logic       WAKEUP;
  logic       WICENACK;
  logic       WICENREQ;
  logic       GATEHCLK;
  logic       ISOLATEn;
  logic       RETAINn;
  logic       PWRDOWN;
  logic [3:0] PMUSTATE;

  modport master (
    output PMUEN, SLEEPING, SLEEPDEEP, WAKEUP, WICENACK,
    input  WICENREQ, GATEHCLK, ISOLATEn, RETAINn, PWRDOWN, PMUSTATE
  );

  modport slave (
    input  PMUEN, SLEEPING, SLEEPDEEP, WAKEUP, WICENACK,
    output WICENREQ, GATEHCLK, ISOLATEn, RETAINn, PWRDOWN, PMUSTATE
  );
endinterface

// File: rtl/cortexm0_wic_pmu.sv
// Always-on PMU: owns the WIC enable handshake and sequences core deep-sleep
// clock gating, isolation, retention and power-down, unwinding on WAKEUP.
module cortexm0_wic_pmu #(
  parameter bit PWRDN_EN     = 1'b1,
  parameter int PWRUP_CYCLES = 4
) (
  input  logic              FCLK,
  input  logic              nRESET,
  cortexm0_wic_pmu_if.slave pmu_if
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    REQ     = 4'd1,
    ARMED   = 4'd2,
    GATE    = 4'd3,
    ISO     = 4'd4,
    RET     = 4'd5,
    OFF     = 4'd6,
    PWRON   = 4'd7,
    RESTORE = 4'd8,
    DEISO   = 4'd9,
    REL     = 4'd10
  } state_e;

  localparam logic [7:0] PWRUP_LOAD = 8'(PWRUP_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       wicenreq_q, wicenreq_d;
  logic       gatehclk_q, gatehclk_d;
  logic       isolaten_q, isolaten_d;
  logic       retainn_q, retainn_d;
  logic       pwrdown_q, pwrdown_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:    if (pmu_if.PMUEN) state_d = REQ;
      REQ: begin
        if (pmu_if.WICENACK)   state_d = ARMED;
        else if (!pmu_if.PMUEN) state_d = REL;
      end
      ARMED: begin
        if (pmu_if.SLEEPING && pmu_if.SLEEPDEEP) state_d = GATE;
        else if (!pmu_if.PMUEN)                  state_d = REL;
      end
      REL:     if (!pmu_if.WICENACK) state_d = IDLE;
      // Once gated only WAKEUP matters; each step unwinds from where it is.
      GATE: begin
        if (pmu_if.WAKEUP) state_d = ARMED;
        else if (PWRDN_EN) state_d = ISO;
      end
      ISO:     state_d = pmu_if.WAKEUP ? DEISO : RET;
      RET:     state_d = pmu_if.WAKEUP ? RESTORE : OFF;
      OFF: begin
        if (pmu_if.WAKEUP) begin
          state_d = PWRON;
          cnt_d   = PWRUP_LOAD;
        end
      end
      PWRON: begin
        if (cnt_q == 8'd0) state_d = RESTORE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      RESTORE: state_d = DEISO;
      DEISO:   state_d = ARMED;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they leave on flops aligned with PMUSTATE.
    wicenreq_d = state_d inside {REQ, ARMED, GATE, ISO, RET, OFF, PWRON, RESTORE, DEISO};
    gatehclk_d = state_d inside {GATE, ISO, RET, OFF, PWRON, RESTORE, DEISO};
    isolaten_d = !(state_d inside {ISO, RET, OFF, PWRON, RESTORE});
    retainn_d  = !(state_d inside {RET, OFF, PWRON});
    pwrdown_d  = (state_d == OFF);
  end

  always_ff @(posedge FCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      wicenreq_q <= 1'b0;
      gatehclk_q <= 1'b0;
      isolaten_q <= 1'b1;
      retainn_q  <= 1'b1;
      pwrdown_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wicenreq_q <= wicenreq_d;
      gatehclk_q <= gatehclk_d;
      isolaten_q <= isolaten_d;
      retainn_q  <= retainn_d;
      pwrdown_q  <= pwrdown_d;
    end
  end

  assign pmu_if.WICENREQ = wicenreq_q;
  assign pmu_if.GATEHCLK = gatehclk_q;
  assign pmu_if.ISOLATEn = isolaten_q;
  assign pmu_if.RETAINn  = retainn_q;
  assign pmu_if.PWRDOWN  = pwrdown_q;
  assign pmu_if.PMUSTATE = state_q;

endmodule
